avalon_shift_sub_array: RTL and testbench

//   NCH-channel Avalon-MM slave computing R[ch] = A[ch]*2^SHIFT - B[ch] per channel.

---
 rtl/avalon_shift_sub_array.sv | 140 ++++++++++++++
 tb/tb_avalon_shift_sub_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_shift_sub_array.sv
// Per-channel R = (A << SHIFT) - B with wrap/saturate, sticky overflow and register readback.
// Result lands 2 cycles after the A/B write; readdata latency 1; no backpressure, one update per cycle.
module avalon_shift_sub_array #(
    parameter int N     = 32,
    parameter int NCH   = 4,
    parameter int SHIFT = 3
) (
    input  logic             csi_clk,
    input  logic             rsi_srst_n,
    input  logic [7:0]       avs_s0_address,
    input  logic             avs_s0_write,
    input  logic [N-1:0]     avs_s0_writedata,
    input  logic             avs_s0_read,
    output logic [N-1:0]     avs_s0_readdata,
    output logic [NCH*N-1:0] coe_R,
    output logic [NCH-1:0]   coe_valid,
    output logic [NCH-1:0]   coe_ovf
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int W  = N + SHIFT + 1;

    logic [N-1:0]   a_q [NCH];
    logic [N-1:0]   b_q [NCH];
    logic [N-1:0]   r_q [NCH];
    logic           sat_q;
    logic [NCH-1:0] status_q, status_d;
    logic           p0_vld_q;
    logic [CW-1:0]  p0_ch_q;
    logic           s1_vld_q;
    logic [CW-1:0]  s1_ch_q;
    logic [N-1:0]   s1_r_q, s1_r_d;
    logic           s1_ovf_q, s1_ovf_d;
    logic [NCH-1:0] valid_q, valid_d;
    logic [N-1:0]   rdata_q, rdata_d;

    logic [5:0]     addr_ch;
    logic [1:0]     addr_sub;
    logic [CW-1:0]  ch_idx;
    logic           ch_ok;
    logic           wr_ab;
    logic           wr_ctrl;
    logic           wr_status;

    assign addr_ch   = avs_s0_address[7:2];
    assign addr_sub  = avs_s0_address[1:0];
    assign ch_idx    = CW'(addr_ch);
    assign ch_ok     = (int'(addr_ch) < NCH);
    assign wr_ab     = avs_s0_write && ch_ok && (addr_sub < 2'd2);
    assign wr_ctrl   = avs_s0_write && (avs_s0_address == 8'hFC);
    assign wr_status = avs_s0_write && (avs_s0_address == 8'hFD);

    // Stage 1: exact difference in W bits; the sign bit flags underflow, bits above N flag overflow.
    logic [W-1:0] e;
    logic         e_neg;
    logic         e_big;
    always_comb begin
        e        = (W'(a_q[p0_ch_q]) << SHIFT) - W'(b_q[p0_ch_q]);
        e_neg    = e[W-1];
        e_big    = !e_neg && ((e >> N) != '0);
        s1_ovf_d = e_neg || e_big;
        s1_r_d   = e[N-1:0];
        if (sat_q && e_neg) begin
            s1_r_d = '0;
        end else if (sat_q && e_big) begin
            s1_r_d = '1;
        end
    end

    logic [NCH-1:0] st_set;
    logic [NCH-1:0] st_clr;
    always_comb begin
        valid_d  = s1_vld_q ? (NCH'(1) << s1_ch_q) : '0;
        st_set   = s1_ovf_q ? valid_d : '0;
        st_clr   = wr_status ? NCH'(avs_s0_writedata) : '0;
        status_d = (status_q & ~st_clr) | st_set;
    end

    // Read mux uses pre-edge state, so a simultaneous write is not visible.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_s0_read) begin
            rdata_d = '0;
            if (ch_ok) begin
                case (addr_sub)
                    2'd0:    rdata_d = a_q[ch_idx];
                    2'd1:    rdata_d = b_q[ch_idx];
                    2'd2:    rdata_d = r_q[ch_idx];
                    default: rdata_d = '0;
                endcase
            end else if (avs_s0_address == 8'hFC) begin
                rdata_d = N'(sat_q);
            end else if (avs_s0_address == 8'hFD) begin
                rdata_d = N'(status_q);
            end
        end
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_srst_n) begin
            for (int i = 0; i < NCH; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
            sat_q    <= 1'b0;
            status_q <= '0;
            p0_vld_q <= 1'b0;
            p0_ch_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_ch_q  <= '0;
            s1_r_q   <= '0;
            s1_ovf_q <= 1'b0;
            valid_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_ab) begin
                if (addr_sub == 2'd0) a_q[ch_idx] <= avs_s0_writedata;
                else                  b_q[ch_idx] <= avs_s0_writedata;
            end
            if (wr_ctrl) sat_q <= avs_s0_writedata[0];
            p0_vld_q <= wr_ab;
            p0_ch_q  <= ch_idx;
            s1_vld_q <= p0_vld_q;
            s1_ch_q  <= p0_ch_q;
            s1_r_q   <= s1_r_d;
            s1_ovf_q <= s1_ovf_d;
            if (s1_vld_q) r_q[s1_ch_q] <= s1_r_q;
            valid_q  <= valid_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign coe_R[g*N +: N] = r_q[g];
    end
    assign coe_valid       = valid_q;
    assign coe_ovf         = status_q;
    assign avs_s0_readdata = rdata_q;
endmodule

// File: tb/tb_avalon_shift_sub_array.sv
// Directed and random bus traffic against a per-register behavioural model of the shift-subtract slave.
module tb_avalon_shift_sub_array;
    logic         csi_clk = 1'b0;
    logic         rsi_srst_n = 1'b0;
    logic [7:0]   avs_s0_address = '0;
    logic         avs_s0_write = 1'b0;
    logic [31:0]  avs_s0_writedata = '0;
    logic         avs_s0_read = 1'b0;
    logic [31:0]  avs_s0_readdata;
    logic [127:0] coe_R;
    logic [3:0]   coe_valid;
    logic [3:0]   coe_ovf;

    avalon_shift_sub_array #(.N(32), .NCH(4), .SHIFT(3)) dut (
        .csi_clk(csi_clk), .rsi_srst_n(rsi_srst_n),
        .avs_s0_address(avs_s0_address), .avs_s0_write(avs_s0_write),
        .avs_s0_writedata(avs_s0_writedata), .avs_s0_read(avs_s0_read),
        .avs_s0_readdata(avs_s0_readdata), .coe_R(coe_R),
        .coe_valid(coe_valid), .coe_ovf(coe_ovf)
    );

    always #5 csi_clk = ~csi_clk;

    typedef struct {
        int          due;
        int          ch;
        logic [31:0] r;
        logic        ovf;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    ent_t        pend [$];
    logic [31:0] ma [4];
    logic [31:0] mb [4];
    logic [31:0] mr [4];
    logic        msat;
    logic [3:0]  mstatus;
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact integer result, then the overflow/saturation rules applied to it.
    function automatic logic [32:0] calc(input logic [31:0] a, input logic [31:0] b, input logic sat);
        longint      e;
        logic        ovf;
        logic [31:0] r;
        e   = longint'({32'd0, a}) * 8 - longint'({32'd0, b});
        ovf = (e < 0) || (e > 64'sd4294967295);
        r   = e[31:0];
        if (sat && e < 0) r = '0;
        else if (sat && ovf) r = '1;
        return {ovf, r};
    endfunction

    function automatic logic [31:0] rd_model(input logic [7:0] addr);
        int c;
        int s;
        c = int'(addr) / 4;
        s = int'(addr) % 4;
        if (c < 4) begin
            if (s == 0) return ma[c];
            if (s == 1) return mb[c];
            if (s == 2) return mr[c];
            return '0;
        end
        if (addr == 8'hFC) return {31'd0, msat};
        if (addr == 8'hFD) return {28'd0, mstatus};
        return '0;
    endfunction

    task automatic tick();
        logic [3:0]   vexp;
        logic [3:0]   set;
        logic [3:0]   clr;
        logic [127:0] rexp;
        logic [32:0]  res;
        int           c;
        int           s;
        vexp = '0;
        set  = '0;
        @(posedge csi_clk);
        cyc++;
        if (!rsi_srst_n) begin
            for (int i = 0; i < 4; i++) begin
                ma[i] = '0; mb[i] = '0; mr[i] = '0;
            end
            msat = 1'b0; mstatus = '0; exp_rd = '0;
            pend.delete();
        end else begin
            if (avs_s0_read) exp_rd = rd_model(avs_s0_address);
            for (int i = 0; i < pend.size(); ) begin
                if (pend[i].due == cyc) begin
                    vexp[pend[i].ch] = 1'b1;
                    mr[pend[i].ch]   = pend[i].r;
                    if (pend[i].ovf) set[pend[i].ch] = 1'b1;
                    pend.delete(i);
                end else begin
                    i++;
                end
            end
            clr = (avs_s0_write && avs_s0_address == 8'hFD) ? avs_s0_writedata[3:0] : 4'd0;
            mstatus = (mstatus & ~clr) | set;
            if (avs_s0_write) begin
                c = int'(avs_s0_address) / 4;
                s = int'(avs_s0_address) % 4;
                if (c < 4 && s < 2) begin
                    if (s == 0) ma[c] = avs_s0_writedata;
                    else        mb[c] = avs_s0_writedata;
                    res = calc(ma[c], mb[c], msat);
                    pend.push_back('{due: cyc + 2, ch: c, r: res[31:0], ovf: res[32]});
                end
                if (avs_s0_address == 8'hFC) msat = avs_s0_writedata[0];
            end
        end
        #1;
        rexp = {mr[3], mr[2], mr[1], mr[0]};
        chk("valid", 128'(coe_valid), 128'(vexp));
        chk("coe_R", coe_R, rexp);
        chk("ovf", 128'(coe_ovf), 128'(mstatus));
        chk("readdata", 128'(avs_s0_readdata), 128'(exp_rd));
    endtask

    task automatic op(input logic w, input logic r, input logic [7:0] addr, input logic [31:0] d);
        @(negedge csi_clk);
        rsi_srst_n       = 1'b1;
        avs_s0_write     = w;
        avs_s0_read      = r;
        avs_s0_address   = addr;
        avs_s0_writedata = d;
        tick();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] d);
        op(1'b1, 1'b0, addr, d);
    endtask

    task automatic rd(input logic [7:0] addr);
        op(1'b0, 1'b1, addr, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic rst_cycle();
        @(negedge csi_clk);
        rsi_srst_n   = 1'b0;
        avs_s0_write = 1'b0;
        avs_s0_read  = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'd0;
            2:       return 32'($urandom_range(0, 15));
            3:       return 32'h1FFF_FFFF + 32'($urandom_range(0, 2));
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [7:0] rnd_addr();
        case ($urandom_range(0, 9))
            7:       return 8'hFC;
            8:       return 8'hFD;
            9:       return 8'($urandom_range(0, 255));
            default: return 8'($urandom_range(0, 19));
        endcase
    endfunction

    initial begin
        rst_cycle();
        rst_cycle();
        chk("reset_R", coe_R, 128'd0);
        chk("reset_rd", 128'(avs_s0_readdata), 128'd0);

        wr(8'h00, 32'd5);
        idle(2);
        chk("basic_valid_a", 128'(coe_valid), 128'd1);
        chk("basic_R_a", 128'(coe_R[31:0]), 128'd40);
        wr(8'h01, 32'd7);
        idle(2);
        chk("basic_valid_b", 128'(coe_valid), 128'd1);
        chk("basic_R_b", 128'(coe_R[31:0]), 128'd33);
        chk("basic_ovf", 128'(coe_ovf), 128'd0);

        rd(8'h02);
        chk("rd_R0", 128'(avs_s0_readdata), 128'd33);
        rd(8'hFE);
        chk("rd_FE", 128'(avs_s0_readdata), 128'd0);
        rd(8'h10);
        chk("rd_ch4", 128'(avs_s0_readdata), 128'd0);

        wr(8'h01, 32'd0);
        wr(8'h00, 32'h2000_0000);
        idle(2);
        chk("posovf_wrap", 128'(coe_R[31:0]), 128'd0);
        chk("posovf_flag", 128'(coe_ovf[0]), 128'd1);
        wr(8'hFC, 32'd1);
        wr(8'h00, 32'h2000_0000);
        idle(2);
        chk("posovf_sat", 128'(coe_R[31:0]), 128'hFFFF_FFFF);

        op(1'b1, 1'b1, 8'h00, 32'h1234);
        chk("rw_same_cycle", 128'(avs_s0_readdata), 128'h2000_0000);
        idle(2);

        wr(8'hFC, 32'd0);
        wr(8'hFD, 32'hF);
        wr(8'h05, 32'd1);
        idle(2);
        chk("under_wrap", 128'(coe_R[63:32]), 128'hFFFF_FFFF);
        wr(8'hFC, 32'd1);
        wr(8'h05, 32'd1);
        idle(2);
        chk("under_sat", 128'(coe_R[63:32]), 128'd0);
        rd(8'hFD);
        chk("status_rd", 128'(avs_s0_readdata), 128'h2);
        wr(8'hFD, 32'h2);
        rd(8'hFD);
        chk("status_w1c", 128'(avs_s0_readdata), 128'h0);
        wr(8'h05, 32'd1);
        idle(1);
        wr(8'hFD, 32'h2);
        rd(8'hFD);
        chk("status_set_wins", 128'(avs_s0_readdata), 128'h2);

        wr(8'h0C, 32'd1);
        idle(2);
        chk("iso_valid", 128'(coe_valid), 128'h8);
        chk("iso_R3", 128'(coe_R[127:96]), 128'd8);

        for (int k = 0; k < 400; k++) begin
            op(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4), rnd_addr(), rnd_data());
        end
        idle(3);

        wr(8'h00, 32'd1);
        rst_cycle();
        idle(3);
        chk("midrst_R", coe_R, 128'd0);
        chk("midrst_valid", 128'(coe_valid), 128'd0);
        chk("midrst_ovf", 128'(coe_ovf), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
